// File: rtl/stack_sequencer.sv
// Stack command sequencer: runs PUSH/POP/PEEK/LOAD_SP by reading SP from the register file,
// touching data memory, and writing SP back. The stack grows downward from STACK_BASE.
module stack_sequencer #(
  parameter int               WIDTH       = 16,
  parameter logic [3:0]       SP_ADDR     = 4'd4,
  parameter logic [WIDTH-1:0] STACK_BASE  = 16'h0100,
  parameter logic [WIDTH-1:0] STACK_LIMIT = 16'h00F0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmdValid,
  input  logic [1:0]       cmdOp,
  input  logic [WIDTH-1:0] cmdData,
  output logic             cmdReady,
  output logic             resultValid,
  output logic [WIDTH-1:0] resultData,
  output logic             resultError,
  output logic             regRead,
  output logic             regWrite,
  output logic [3:0]       regAddress,
  output logic [WIDTH-1:0] regWriteData,
  input  logic [WIDTH-1:0] regReadData,
  output logic             memRead,
  output logic             memWrite,
  output logic [WIDTH-1:0] memAddress,
  output logic [WIDTH-1:0] memWriteData,
  input  logic [WIDTH-1:0] memReadData,
  input  logic             memReady
);

  typedef enum logic [2:0] {S_IDLE, S_RD_SP, S_CHECK, S_MEM, S_WR_SP, S_DONE} state_e;
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_PEEK, OP_LOAD} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] resData_q, resData_d;
  logic             resErr_q, resErr_d;
  logic             ready_q;

  logic [WIDTH-1:0] spDec, spInc;
  logic             loadBad, checkErr;

  assign spDec    = sp_q - WIDTH'(1);
  assign spInc    = sp_q + WIDTH'(1);
  assign loadBad  = (data_q > STACK_BASE) || (data_q < STACK_LIMIT);
  assign checkErr = ((op_q == OP_PUSH) && (sp_q == STACK_LIMIT)) ||
                    (((op_q == OP_POP) || (op_q == OP_PEEK)) && (sp_q == STACK_BASE));

  // ready_q keeps cmdReady low until the first edge after reset is released.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      resData_q <= '0;
      resErr_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      resData_q <= resData_d;
      resErr_q  <= resErr_d;
      ready_q   <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    op_q   <= op_d;
    data_q <= data_d;
    sp_q   <= sp_d;
  end

  assign regAddress   = SP_ADDR;
  assign memAddress   = (op_q == OP_PUSH) ? spDec : sp_q;
  assign memWriteData = data_q;
  assign cmdReady     = (state_q == S_IDLE) && ready_q;
  assign resultValid  = (state_q == S_DONE);
  assign resultError  = (state_q == S_DONE) && resErr_q;
  assign resultData   = resData_q;

  always_comb begin
    case (op_q)
      OP_PUSH: regWriteData = spDec;
      OP_POP:  regWriteData = spInc;
      default: regWriteData = data_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    sp_d      = sp_q;
    resData_d = resData_q;
    resErr_d  = resErr_q;
    regRead   = 1'b0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmdValid && cmdReady) begin
          op_d     = op_e'(cmdOp);
          data_d   = cmdData;
          resErr_d = 1'b0;
          state_d  = (op_e'(cmdOp) == OP_LOAD) ? S_WR_SP : S_RD_SP;
        end
      end
      S_RD_SP: begin
        regRead = 1'b1;
        sp_d    = regReadData;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (checkErr) begin
          resErr_d  = 1'b1;
          resData_d = sp_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        memWrite = (op_q == OP_PUSH);
        memRead  = (op_q != OP_PUSH);
        if (memReady) begin
          if (op_q != OP_PUSH) resData_d = memReadData;
          state_d = (op_q == OP_PEEK) ? S_DONE : S_WR_SP;
        end
      end
      S_WR_SP: begin
        // A rejected LOAD_SP reads SP here so the error result carries the unchanged value.
        if ((op_q == OP_LOAD) && loadBad) begin
          regRead   = 1'b1;
          resData_d = regReadData;
          resErr_d  = 1'b1;
        end else begin
          regWrite = 1'b1;
          if (op_q != OP_POP) resData_d = regWriteData;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
